// File: rtl/reg_file.sv
// reg_file: 16 x 8-bit register file, two combinational read ports, one
// synchronous write port, and R15 exposed as cpu_out.
//
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset, clears all registers
//   RA1, RA2     : read addresses for RD1 / RD2
//   WA           : write address
//   ALUResult    : write data
//   write_enable : write strobe
//   RD1, RD2     : read data (combinational)
//   cpu_out      : stored R15, never forwarded
//
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle write data
// to RD1/RD2 when the read address matches WA.
module reg_file (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] RA1,
   input  logic [3:0] RA2,
   input  logic [3:0] WA,
   input  logic [7:0] ALUResult,
   input  logic       write_enable,
   output logic [7:0] RD1,
   output logic [7:0] RD2,
   output logic [7:0] cpu_out
);

   logic [7:0] regs [16];

   // Reset wins over a simultaneous write; R0 is an ordinary register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            regs[i] <= 8'h00;
         end
      end else if (write_enable) begin
         regs[WA] <= ALUResult;
      end
   end

`ifdef REG_FILE_BYPASS_EN
   // Forward the write data only for a write that will actually land.
   logic wr_live;

   assign wr_live = write_enable & ~rst;

   always_comb begin
      RD1 = regs[RA1];
      RD2 = regs[RA2];
      if (wr_live && (RA1 == WA)) begin
         RD1 = ALUResult;
      end
      if (wr_live && (RA2 == WA)) begin
         RD2 = ALUResult;
      end
   end
`else
   assign RD1 = regs[RA1];
   assign RD2 = regs[RA2];
`endif

   assign cpu_out = regs[15];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Expected values are hand-computed constants.
module tb_reg_file;

   logic       clk;
   logic       rst;
   logic [3:0] RA1;
   logic [3:0] RA2;
   logic [3:0] WA;
   logic [7:0] ALUResult;
   logic       write_enable;
   logic [7:0] RD1;
   logic [7:0] RD2;
   logic [7:0] cpu_out;

   int n_checks;
   int n_pass;

   reg_file dut (
      .clk          (clk),
      .rst          (rst),
      .RA1          (RA1),
      .RA2          (RA2),
      .WA           (WA),
      .ALUResult    (ALUResult),
      .write_enable (write_enable),
      .RD1          (RD1),
      .RD2          (RD2),
      .cpu_out      (cpu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; return 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      WA = a;
      ALUResult = d;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
   endtask

   logic [7:0] exp_rd;

   initial begin
      n_checks = 0;
      n_pass = 0;
      rst = 1'b1;
      RA1 = 4'd0;
      RA2 = 4'd0;
      WA = 4'd0;
      ALUResult = 8'h00;
      write_enable = 1'b0;
      #2;

      // Reset for one edge, then sweep every address.
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         RA1 = 4'(i);
         RA2 = 4'(15 - i);
         #1;
         check($sformatf("rst_rd1_%0d", i), RD1, 8'h00);
         check($sformatf("rst_rd2_%0d", 15 - i), RD2, 8'h00);
      end
      check("rst_cpu_out", cpu_out, 8'h00);

      // Basic write / read.
      wr(4'd3, 8'h12);
      RA1 = 4'd3;
      #1;
      check("wr_r3", RD1, 8'h12);

      // Write disabled: R6 must stay zero, R3 untouched.
      WA = 4'd6;
      ALUResult = 8'h34;
      write_enable = 1'b0;
      RA1 = 4'd6;
      #1;
      check("nowe_pre_r6", RD1, 8'h00);
      tick();
      RA2 = 4'd6;
      RA1 = 4'd3;
      #1;
      check("nowe_r6", RD2, 8'h00);
      check("nowe_r3", RD1, 8'h12);

      // Dual read, including the same address on both ports.
      wr(4'd9, 8'h56);
      wr(4'd8, 8'h78);
      RA1 = 4'd9;
      RA2 = 4'd8;
      #1;
      check("dual_rd1", RD1, 8'h56);
      check("dual_rd2", RD2, 8'h78);
      RA1 = 4'd8;
      #1;
      check("same_rd1", RD1, 8'h78);
      check("same_rd2", RD2, 8'h78);

      // R0 is writable, distinct from its neighbours.
      wr(4'd0, 8'h9E);
      RA1 = 4'd0;
      RA2 = 4'd1;
      #1;
      check("r0_wr", RD1, 8'h9E);
      check("r1_hold", RD2, 8'h00);

      // cpu_out tracks R15 only.
      wr(4'd15, 8'hA5);
      check("cpu_out_wr", cpu_out, 8'hA5);
      wr(4'd7, 8'h3C);
      check("cpu_out_hold", cpu_out, 8'hA5);
      RA1 = 4'd7;
      RA2 = 4'd15;
      #1;
      check("r7_3c", RD1, 8'h3C);
      check("r15_rd2", RD2, 8'hA5);

      // Reset beats a simultaneous write; no forwarding while in reset.
      rst = 1'b1;
      WA = 4'd15;
      ALUResult = 8'hFF;
      write_enable = 1'b1;
      RA1 = 4'd15;
      RA2 = 4'd3;
      #1;
      check("rstwr_pre_rd1", RD1, 8'hA5);
      tick();
      check("rstwr_cpu_out", cpu_out, 8'h00);
      check("rstwr_r15", RD1, 8'h00);
      check("rstwr_r3", RD2, 8'h00);

      // First edge with rst low accepts the write.
      rst = 1'b0;
      WA = 4'd5;
      ALUResult = 8'hC3;
      tick();
      write_enable = 1'b0;
      RA1 = 4'd5;
      #1;
      check("post_rst_wr", RD1, 8'hC3);

      // Read-during-write to the same address on both ports.
      wr(4'd7, 8'h11);
      WA = 4'd7;
      ALUResult = 8'h22;
      write_enable = 1'b1;
      RA1 = 4'd7;
      RA2 = 4'd7;
`ifdef REG_FILE_BYPASS_EN
      exp_rd = 8'h22;
`else
      exp_rd = 8'h11;
`endif
      #1;
      check("rdw_pre_rd1", RD1, exp_rd);
      check("rdw_pre_rd2", RD2, exp_rd);
      RA2 = 4'd5;
      #1;
      check("rdw_other_rd2", RD2, 8'hC3);
      tick();
      write_enable = 1'b0;
      #1;
      check("rdw_post_rd1", RD1, 8'h22);

      // Fill all entries with a pattern and read it back.
      for (int i = 0; i < 16; i++) begin
         wr(4'(i), 8'(8'h10 * i + i + 1));
      end
      for (int i = 0; i < 16; i++) begin
         RA1 = 4'(i);
         RA2 = 4'(i ^ 5);
         #1;
         check($sformatf("fill_rd1_%0d", i), RD1, 8'(8'h11 * i + 1));
         check($sformatf("fill_rd2_%0d", i ^ 5), RD2,
               8'(8'h11 * (i ^ 5) + 1));
      end
      check("fill_cpu_out", cpu_out, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
